sram_like_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 18 +
 rtl/arb_starve_ctr.sv | 30 +++
 rtl/sram_like_arbiter.sv | 131 +++++++++++++
 tb/tb_sram_like_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the SRAM-like port arbiter.
// States, owner ids and access-size codes.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants made while inst waits.
// Ports: clk, rst, inc, clr in; force_inst out (count at limit).
module arb_starve_ctr #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic force_inst
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] MAXV = CW'(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != MAXV) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_inst = (cnt == MAXV);

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like port between fetch (inst) and load/store (data).
// Ports: inst_*/data_* requester sides, mem_* downstream, busy/owner status.
module sram_like_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  state_t state;
  state_t state_nx;

  logic              owner_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic force_inst;
  logic any_req;
  logic grant;
  logic grant_data;
  logic addr_hit;
  logic data_hit;

  assign any_req    = inst_req | data_req;
  assign grant      = (state == IDLE) & any_req;
  // Data wins ties unless inst has waited out the starvation limit.
  assign grant_data = data_req & ~(inst_req & force_inst);

  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .inc       (grant & grant_data & inst_req),
    .clr       (grant & ~grant_data),
    .force_inst(force_inst)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req)     state_nx = ADDR;
      ADDR:    if (mem_addr_ok) state_nx = DATA;
      DATA:    if (mem_data_ok) state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner_q <= OWN_INST;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        if (grant_data) begin
          owner_q <= OWN_DATA;
          wr_q    <= data_wr;
          size_q  <= data_size;
          addr_q  <= data_addr;
          wdata_q <= data_wdata;
        end else begin
          owner_q <= OWN_INST;
          wr_q    <= 1'b0;
          size_q  <= SZ_W;
          addr_q  <= inst_addr;
          wdata_q <= '0;
        end
      end
    end
  end

  // A reset in the completing cycle abandons the transaction silently.
  assign addr_hit = (state == ADDR) & mem_addr_ok & ~rst;
  assign data_hit = (state == DATA) & mem_data_ok & ~rst;

  assign inst_addr_ok = addr_hit & (owner_q == OWN_INST);
  assign data_addr_ok = addr_hit & (owner_q == OWN_DATA);
  assign inst_data_ok = data_hit & (owner_q == OWN_INST);
  assign data_data_ok = data_hit & (owner_q == OWN_DATA);

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  assign mem_req   = (state == ADDR);
  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign busy  = (state != IDLE);
  assign owner = owner_q;

  a_data_ok_in_data: assert property (
    @(posedge clk) disable iff (rst) mem_data_ok |-> state == DATA
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter with a scripted memory side.
// Per-side request queues double as the expected-transaction store.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        owner;

  sram_like_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .owner       (owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t iq[$];
  txn_t dq[$];

  int n_checks = 0;
  int n_errors = 0;
  int mcnt = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_reqs();
    inst_req = (iq.size() > 0);
    inst_addr = (iq.size() > 0) ? iq[0].addr : 32'h0;
    data_req = (dq.size() > 0);
    if (dq.size() > 0) begin
      data_wr    = dq[0].wr;
      data_size  = dq[0].size;
      data_addr  = dq[0].addr;
      data_wdata = dq[0].wdata;
    end else begin
      data_wr    = 1'b0;
      data_size  = 2'd0;
      data_addr  = 32'h0;
      data_wdata = 32'h0;
    end
  endtask

  task automatic push_i(input logic [31:0] a, input logic [31:0] rd);
    txn_t t;
    t.wr = 1'b0; t.size = 2'd2; t.addr = a; t.wdata = 32'h0; t.rdata = rd;
    iq.push_back(t);
  endtask

  task automatic push_d(input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd);
    txn_t t;
    t.wr = w; t.size = s; t.addr = a; t.wdata = wd; t.rdata = rd;
    dq.push_back(t);
  endtask

  // Plays the memory: accepts after aw wait cycles, completes after dw.
  task automatic serve(input int aw, input int dw);
    int n;
    logic wd;
    txn_t t;
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req) begin
      chk("mem_req_timeout", 32'(mem_req), 32'd1);
      return;
    end
    wd = data_req && !(inst_req && mcnt == 8);
    if (wd && inst_req) begin
      if (mcnt < 8) mcnt++;
    end else if (!wd) begin
      mcnt = 0;
    end
    if (wd) t = dq[0];
    else t = iq[0];
    chk("owner", 32'(owner), 32'(wd));
    chk("busy_addr", 32'(busy), 32'd1);
    chk("mem_wr", 32'(mem_wr), 32'(t.wr));
    chk("mem_size", 32'(mem_size), 32'(t.size));
    chk("mem_addr", mem_addr, t.addr);
    if (wd) chk("mem_wdata", mem_wdata, t.wdata);
    for (int i = 0; i < aw; i++) begin
      chk("early_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      @(negedge clk);
      chk("hold_req", 32'(mem_req), 32'd1);
      chk("hold_addr", mem_addr, t.addr);
      chk("hold_size", 32'(mem_size), 32'(t.size));
    end
    mem_addr_ok = 1'b1;
    #1;
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(!wd));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(wd));
    @(posedge clk);
    #1;
    mem_addr_ok = 1'b0;
    if (wd) void'(dq.pop_front());
    else void'(iq.pop_front());
    drive_reqs();
    for (int i = 0; i < dw; i++) begin
      @(negedge clk);
      chk("data_req_low", 32'(mem_req), 32'd0);
      chk("early_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    end
    @(negedge clk);
    mem_data_ok = 1'b1;
    mem_rdata = t.rdata;
    #1;
    chk("inst_data_ok", 32'(inst_data_ok), 32'(!wd));
    chk("data_data_ok", 32'(data_data_ok), 32'(wd));
    if (wd) chk("data_rdata", data_rdata, t.rdata);
    else chk("inst_rdata", inst_rdata, t.rdata);
    @(posedge clk);
    #1;
    mem_data_ok = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata = 32'h0;
    drive_reqs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_size", 32'(mem_size), 32'd0);
    chk("rst_oks", 32'({inst_addr_ok, inst_data_ok,
                        data_addr_ok, data_data_ok}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Inst only fetch.
    push_i(32'hBFC00000, 32'h3C1D0001);
    drive_reqs();
    serve(1, 1);

    // Simultaneous store and fetch: data first, then inst.
    @(posedge clk);
    #1;
    push_d(1'b1, 2'd2, 32'h80001000, 32'hDEADBEEF, 32'h0);
    push_i(32'hBFC00004, 32'h24080005);
    drive_reqs();
    serve(0, 0);
    serve(0, 0);

    // Downstream withholds accept for 5 cycles.
    @(posedge clk);
    #1;
    push_d(1'b0, 2'd2, 32'h80002000, 32'h0, 32'h12345678);
    drive_reqs();
    serve(5, 2);

    // Byte load passes size and address unchanged.
    @(posedge clk);
    #1;
    push_d(1'b0, 2'd0, 32'h80000003, 32'h0, 32'h000000A5);
    drive_reqs();
    serve(0, 1);

    // Starvation guard: 8 data grants, one inst, then data again.
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++)
      push_d(1'b0, 2'd2, 32'h80003000 + 32'(i * 4), 32'h0, 32'hA000 + 32'(i));
    push_i(32'hBFC00100, 32'h11110000);
    push_i(32'hBFC00104, 32'h22220000);
    drive_reqs();
    for (int i = 0; i < 12; i++) begin
      if (i == 8) begin
        @(negedge clk);
        @(negedge clk);
        chk("starve_inst_win", 32'(owner), 32'd0);
        @(posedge clk);
        #1;
        mem_addr_ok = 1'b1;
        @(posedge clk);
        #1;
        mem_addr_ok = 1'b0;
        void'(iq.pop_front());
        mcnt = 0;
        drive_reqs();
        @(posedge clk);
        #1;
        mem_data_ok = 1'b1;
        @(posedge clk);
        #1;
        mem_data_ok = 1'b0;
        @(negedge clk);
      end else begin
        serve(0, 0);
      end
    end

    // Reset in DATA while completion arrives: no ok pulse.
    @(posedge clk);
    #1;
    push_d(1'b0, 2'd2, 32'h80004000, 32'h0, 32'h55AA55AA);
    drive_reqs();
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_case_req", 32'(mem_req), 32'd1);
    mem_addr_ok = 1'b1;
    @(posedge clk);
    #1;
    mem_addr_ok = 1'b0;
    void'(dq.pop_front());
    drive_reqs();
    @(negedge clk);
    mem_data_ok = 1'b1;
    mem_rdata = 32'h55AA55AA;
    rst = 1'b1;
    #1;
    chk("rst_no_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_data_ok = 1'b0;
    mcnt = 0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_req", 32'(mem_req), 32'd0);
    chk("post_rst_addr", mem_addr, 32'h0);

    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
